spi_reg_master: RTL and testbench
=================================

SPI_REG_MASTER -- requirements
Module: spi_reg_master

Interface
REQ-001 Parameter: CLK_DIV, 4, clk cycles per spi_clk half-period; legal range 2..255; 4 or more is needed against a 2-stage-synchronised target.
REQ-002 Parameter: ADDR_W, 4, register address width; legal range 1..7.
REQ-003 Port: clk  input  1  sole clock; all logic on posedge clk.
REQ-004 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port: req_valid  input  1  request offered.
REQ-006 Port: req_ready  output  1  block can accept a request.
REQ-007 Port: req_write  input  1  1=register write, 0=register read.
REQ-008 Port: req_addr  input  ADDR_W  target register address.
REQ-009 Port: req_wdata  input  8  write data.
REQ-010 Port: rsp_valid  output  1  one-cycle pulse, transaction complete.
REQ-011 Port: rsp_rdata  output  8  read data, valid while rsp_valid=1.
REQ-012 Port: spi_cs_n / spi_clk / spi_mosi  output  1 each  SPI initiator lines, mode 0.
REQ-013 Port: spi_miso  input  1  target read data.

Function
REQ-014 A request is accepted on a clk edge where req_valid=1 and req_ready=1; req_write, req_addr and req_wdata are captured on that edge.
REQ-015 req_ready is 1 only in IDLE; requests offered in any other state are ignored and not queued.
REQ-016 Frame: 16 bits, MSB first: header bit7 = req_write, bits6:ADDR_W = 0, bits ADDR_W-1:0 = req_addr, then 8 data bits (req_wdata for a write, 0 driven for a read).
REQ-017 States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE. No other transitions exist, except reset.
REQ-018 SETUP: entered on the edge after acceptance; spi_cs_n=0, spi_clk=0; spi_mosi = frame bit15; lasts CLK_DIV cycles.
REQ-019 SHIFT: each bit is CLK_DIV cycles spi_clk=1, then CLK_DIV cycles spi_clk=0; spi_mosi updates to the next bit on each falling spi_clk; 16 rising edges total.
REQ-020 During bits 7..0, spi_miso is sampled on the last clk cycle of each spi_clk-high phase and shifted into an 8-bit register, MSB first.
REQ-021 HOLD: spi_cs_n=0, spi_clk=0, spi_mosi=0; lasts CLK_DIV cycles.
REQ-022 GAP: spi_cs_n=1 on entry; rsp_valid=1 on the first GAP cycle only; lasts CLK_DIV cycles, then IDLE.
REQ-023 rsp_rdata = the shifted miso byte for a read, 8'h00 for a write.
REQ-024 Latency: with acceptance at cycle 0, spi_cs_n falls at cycle 1, rsp_valid is at cycle 34*CLK_DIV+1, and req_ready returns at 35*CLK_DIV+1.
REQ-025 In IDLE: spi_cs_n=1, spi_clk=0, spi_mosi=0.
REQ-026 The divider counter wraps at CLK_DIV-1; the bit counter wraps at 15. No counter overflows for legal parameters.

Reset
REQ-027 Asserting rst_n=0 at any time, including mid-frame, immediately forces IDLE, spi_cs_n=1, spi_clk=0, spi_mosi=0, rsp_valid=0 and rsp_rdata=0, and clears all counters.
REQ-028 req_ready is 0 while rst_n=0 and becomes 1 on the first clk edge after release.
REQ-029 A transaction interrupted by reset produces no rsp_valid.

Structure
REQ-030 Package spi_reg_pkg holds: the state enum, FRAME_BITS=16, HDR_WRITE_BIT=7 and the default CLK_DIV.
REQ-031 A single sub-module, spi_clk_div, generates the half-period tick from CLK_DIV and is restartable by the FSM.
REQ-032 Outputs spi_cs_n, spi_clk and spi_mosi are registered, not combinational.

Verification
REQ-033 Write: CLK_DIV=4, write addr 4'h3, data 8'hA5 -> mosi frame 16'h83A5 on 16 rising edges; rsp_valid at cycle 137; rsp_rdata=8'h00.
REQ-034 Read: the bench spi_reg target model returns 8'h5C at addr 4'hC -> mosi header 8'h0C; rsp_rdata=8'h5C when rsp_valid=1.
REQ-035 Back-to-back: req_valid held high with two requests -> second accepted at cycle 141; spi_cs_n high for at least CLK_DIV cycles between frames.
REQ-036 Busy: req_valid pulsed during SHIFT -> ignored; exactly one frame and one rsp_valid.
REQ-037 Reset mid-frame: rst_n low after the 5th rising spi_clk -> spi_cs_n=1 and spi_clk=0 immediately; no rsp_valid; next request completes normally.
REQ-038 Divider: CLK_DIV=2 and CLK_DIV=7 -> spi_clk high and low phases exactly 2 and 7 cycles; latency matches REQ-024.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared constants and FSM state encoding for the SPI register
// master slice.
//   FRAME_BITS      - bits per SPI frame (8 header + 8 data)
//   HDR_WRITE_BIT   - header bit that carries the write flag
//   CLK_DIV_DEFAULT - default clk cycles per spi_clk half-period
//   ADDR_W_DEFAULT  - default register address width
//   state_t / ST_*  - FSM state encoding
package spi_reg_pkg;

  localparam int FRAME_BITS      = 16;
  localparam int HDR_WRITE_BIT   = 7;
  localparam int CLK_DIV_DEFAULT = 4;
  localparam int ADDR_W_DEFAULT  = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SETUP = 3'd1;
  localparam state_t ST_SHIFT = 3'd2;
  localparam state_t ST_HOLD  = 3'd3;
  localparam state_t ST_GAP   = 3'd4;

endpackage

// File: rtl/spi_reg_master_if.sv
// spi_reg_master_if: request/response bus of the SPI register master.
//   req_valid/req_ready - request handshake
//   req_write           - 1 = register write, 0 = register read
//   req_addr            - target register address (ADDR_W bits)
//   req_wdata           - write data
//   rsp_valid           - one-cycle completion pulse
//   rsp_rdata           - read data, valid with rsp_valid
// Modports: master = requester side, slave = spi_reg_master side.
interface spi_reg_master_if
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic              rsp_valid;
  logic [7:0]        rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period tick generator for the SPI master.
//   clk, rst_n - clock, asynchronous active-low reset
//   restart    - holds the counter at zero so the next phase starts clean
//   tick       - high on the last clk cycle of each CLK_DIV-cycle phase
module spi_clk_div
  import spi_reg_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  logic [7:0] cnt;

  assign tick = (cnt == 8'(CLK_DIV - 1));

  // Counts 0..CLK_DIV-1 and wraps; every FSM phase is exactly one wrap long.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (restart || tick) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_reg_master.sv
// spi_reg_master: issues 16-bit mode-0 SPI register frames
// ({write, 0.., addr} header then 8 data bits, MSB first).
//   clk, rst_n         - clock, asynchronous active-low reset
//   bus                - request/response interface (slave modport)
//   spi_cs_n/clk/mosi  - registered SPI initiator outputs
//   spi_miso           - target read data
module spi_reg_master
  import spi_reg_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int ADDR_W  = ADDR_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_reg_master_if.slave bus,
  output logic            spi_cs_n,
  output logic            spi_clk,
  output logic            spi_mosi,
  input  logic            spi_miso
);

  state_t                  state;
  logic [FRAME_BITS-2:0]   tx_sr;
  logic [7:0]              rx_sr;
  logic [3:0]              bit_cnt;
  logic                    is_write;
  logic                    ready_q;
  logic                    rsp_valid_q;
  logic [7:0]              rsp_rdata_q;
  logic                    tick;
  logic                    accept;
  logic [ADDR_W-1:0]       addr;
  logic [7:0]              header;

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  assign accept = bus.req_valid && ready_q;
  assign addr   = bus.req_addr;

  // ADDR_W is at most 7, so zero-extending the address leaves the write
  // flag position free.
  always_comb begin
    header                = 8'(addr);
    header[HDR_WRITE_BIT] = bus.req_write;
  end

  // Divider is parked at zero in IDLE so SETUP starts a full phase after
  // acceptance.
  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (state == ST_IDLE),
    .tick    (tick)
  );

  // Frame FSM. Outputs are registered together with the state so they
  // change on the same edge as the state they belong to. tx_sr holds the
  // 15 frame bits still to send; mosi already carries the current bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      tx_sr       <= '0;
      rx_sr       <= 8'h00;
      bit_cnt     <= 4'd0;
      is_write    <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      spi_cs_n    <= 1'b1;
      spi_clk     <= 1'b0;
      spi_mosi    <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            ready_q  <= 1'b0;
            state    <= ST_SETUP;
            spi_cs_n <= 1'b0;
            spi_clk  <= 1'b0;
            spi_mosi <= header[7];
            tx_sr    <= {header[6:0], (bus.req_write ? bus.req_wdata : 8'h00)};
            is_write <= bus.req_write;
            bit_cnt  <= 4'd0;
            rx_sr    <= 8'h00;
          end
        end
        ST_SETUP: begin
          if (tick) begin
            state   <= ST_SHIFT;
            spi_clk <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (spi_clk) begin
              // End of high phase: sample miso for data bits, then fall
              // and present the next bit.
              spi_clk <= 1'b0;
              if (bit_cnt[3]) begin
                rx_sr <= {rx_sr[6:0], spi_miso};
              end
              spi_mosi <= tx_sr[FRAME_BITS-2];
              tx_sr    <= tx_sr << 1;
            end else if (bit_cnt == 4'(FRAME_BITS - 1)) begin
              state    <= ST_HOLD;
              bit_cnt  <= 4'd0;
              spi_mosi <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              spi_clk <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            state       <= ST_GAP;
            spi_cs_n    <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= is_write ? 8'h00 : rx_sr;
          end
        end
        ST_GAP: begin
          if (tick) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_master.sv
// tb_spi_reg_master: self-checking bench for spi_reg_master. Three DUTs
// (CLK_DIV = 4, 2, 7) share clock, reset and an spi_reg target model; sel
// picks which one is driven and observed.
module tb_spi_reg_master;

  typedef struct {
    int         sel;
    logic       write;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [15:0] exp_frame;
    logic [7:0] exp_rdata;
  } vec_t;

  logic       clk;
  logic       rst_n;
  int         sel;
  logic       req_valid;
  logic       req_write;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       spi_miso;

  logic cs4, sc4, mo4, cs2, sc2, mo2, cs7, sc7, mo7;

  logic       m_cs_n, m_clk, m_mosi, m_ready, m_valid, m_rsp_valid;
  logic [7:0] m_rdata;

  int n_compared   = 0;
  int n_mismatched = 0;

  // monitor / target model state
  int          cyc;
  int          acc_cnt, acc_cyc, rsp_cnt, rsp_cyc, ready_cyc;
  int          frame_cnt, cs_fall_cyc, cs_run, gap_len;
  int          rise_cnt, run, hi_min, hi_max, lo_min, lo_max;
  logic        seen_high, prev_cs, prev_clk, prev_ready;
  logic [15:0] mosi_frame;
  logic [7:0]  rsp_data, tgt_hdr, tgt_tx;
  logic [7:0]  regs [16];

  vec_t vecs [11];

  spi_reg_master_if #(.ADDR_W(4)) if4 ();
  spi_reg_master_if #(.ADDR_W(4)) if2 ();
  spi_reg_master_if #(.ADDR_W(4)) if7 ();

  assign if4.req_valid = req_valid && (sel == 0);
  assign if2.req_valid = req_valid && (sel == 1);
  assign if7.req_valid = req_valid && (sel == 2);
  assign if4.req_write = req_write;
  assign if2.req_write = req_write;
  assign if7.req_write = req_write;
  assign if4.req_addr  = req_addr;
  assign if2.req_addr  = req_addr;
  assign if7.req_addr  = req_addr;
  assign if4.req_wdata = req_wdata;
  assign if2.req_wdata = req_wdata;
  assign if7.req_wdata = req_wdata;

  spi_reg_master #(.CLK_DIV(4), .ADDR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4),
    .spi_cs_n(cs4), .spi_clk(sc4), .spi_mosi(mo4), .spi_miso(spi_miso)
  );
  spi_reg_master #(.CLK_DIV(2), .ADDR_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2),
    .spi_cs_n(cs2), .spi_clk(sc2), .spi_mosi(mo2), .spi_miso(spi_miso)
  );
  spi_reg_master #(.CLK_DIV(7), .ADDR_W(4)) dut7 (
    .clk(clk), .rst_n(rst_n), .bus(if7),
    .spi_cs_n(cs7), .spi_clk(sc7), .spi_mosi(mo7), .spi_miso(spi_miso)
  );

  // Observe the selected DUT.
  always_comb begin
    m_cs_n = cs4; m_clk = sc4; m_mosi = mo4;
    m_ready = if4.req_ready; m_valid = if4.req_valid;
    m_rsp_valid = if4.rsp_valid; m_rdata = if4.rsp_rdata;
    if (sel == 1) begin
      m_cs_n = cs2; m_clk = sc2; m_mosi = mo2;
      m_ready = if2.req_ready; m_valid = if2.req_valid;
      m_rsp_valid = if2.rsp_valid; m_rdata = if2.rsp_rdata;
    end else if (sel == 2) begin
      m_cs_n = cs7; m_clk = sc7; m_mosi = mo7;
      m_ready = if7.req_ready; m_valid = if7.req_valid;
      m_rsp_valid = if7.rsp_valid; m_rdata = if7.rsp_rdata;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int div_of(input int s);
    return (s == 1) ? 2 : ((s == 2) ? 7 : 4);
  endfunction

  // Monitor plus spi_reg target model, sampled on the falling clk edge.
  initial begin
    acc_cnt = 0; acc_cyc = 0; rsp_cnt = 0; rsp_cyc = 0; ready_cyc = 0;
    frame_cnt = 0; cs_fall_cyc = 0; cs_run = 0; gap_len = 0;
    rise_cnt = 0; run = 0; hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
    seen_high = 1'b0; prev_cs = 1'b1; prev_clk = 1'b0; prev_ready = 1'b0;
    mosi_frame = 16'h0; rsp_data = 8'h0; tgt_hdr = 8'h0; tgt_tx = 8'h0;
    spi_miso = 1'b0;
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    regs[0]  = 8'h81;
    regs[12] = 8'h5C;
    forever begin
      @(negedge clk);
      if (m_valid && m_ready) begin acc_cnt++; acc_cyc = cyc; end
      if (m_rsp_valid) begin rsp_cnt++; rsp_cyc = cyc; rsp_data = m_rdata; end
      if (m_ready && !prev_ready) ready_cyc = cyc;
      if (m_cs_n) begin
        cs_run++;
      end else if (prev_cs) begin
        frame_cnt++; cs_fall_cyc = cyc; gap_len = cs_run; cs_run = 0;
        rise_cnt = 0; mosi_frame = 16'h0; run = 1; seen_high = 1'b0;
        hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
        spi_miso = 1'b0;
      end else if (m_clk == prev_clk) begin
        run++;
      end else begin
        if (m_clk) begin
          if (seen_high) begin
            if (run < lo_min) lo_min = run;
            if (run > lo_max) lo_max = run;
          end
          rise_cnt++;
          mosi_frame = {mosi_frame[14:0], m_mosi};
          if (rise_cnt == 8) tgt_hdr = mosi_frame[7:0];
          if (rise_cnt == 16 && tgt_hdr[7]) regs[tgt_hdr[3:0]] = mosi_frame[7:0];
        end else begin
          if (run < hi_min) hi_min = run;
          if (run > hi_max) hi_max = run;
          seen_high = 1'b1;
          if (rise_cnt == 8 && !tgt_hdr[7]) begin
            tgt_tx = regs[tgt_hdr[3:0]];
            spi_miso = tgt_tx[7];
          end else if (rise_cnt > 8 && rise_cnt < 16 && !tgt_hdr[7]) begin
            tgt_tx = tgt_tx << 1;
            spi_miso = tgt_tx[7];
          end
        end
        run = 1;
      end
      prev_cs = m_cs_n; prev_clk = m_clk; prev_ready = m_ready;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One complete transaction on the selected DUT, returning once ready is
  // back and the monitor has recorded it.
  task automatic applyStimulus(input logic w, input logic [3:0] a, input logic [7:0] d);
    int a0, r0, t;
    a0 = acc_cnt;
    r0 = rsp_cnt;
    @(posedge clk); #1;
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    t = 0;
    while (acc_cnt == a0 && t < 50) begin @(posedge clk); #1; t++; end
    req_valid = 1'b0;
    checkOutput("accepted", acc_cnt - a0, 1);
    t = 0;
    while (rsp_cnt == r0 && t < 400) begin @(posedge clk); #1; t++; end
    t = 0;
    while (!m_ready && t < 100) begin @(posedge clk); #1; t++; end
    @(negedge clk); #1;
    checkOutput("rsp_pulses", rsp_cnt - r0, 1);
    checkOutput("ready_back", m_ready, 1);
  endtask

  initial begin
    int d, t, a0, r0, f0, first_acc;
    rst_n = 1'b0; sel = 0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 4'h0; req_wdata = 8'h00;

    vecs[0]  = '{0, 1'b1, 4'h3, 8'hA5, 16'h83A5, 8'h00};
    vecs[1]  = '{0, 1'b0, 4'hC, 8'h00, 16'h0C00, 8'h5C};
    vecs[2]  = '{0, 1'b1, 4'h7, 8'h3C, 16'h873C, 8'h00};
    vecs[3]  = '{0, 1'b0, 4'h7, 8'hEE, 16'h0700, 8'h3C};
    vecs[4]  = '{0, 1'b1, 4'hF, 8'hFF, 16'h8FFF, 8'h00};
    vecs[5]  = '{0, 1'b0, 4'h0, 8'h00, 16'h0000, 8'h81};
    vecs[6]  = '{0, 1'b0, 4'hF, 8'h00, 16'h0F00, 8'hFF};
    vecs[7]  = '{1, 1'b1, 4'h3, 8'hA5, 16'h83A5, 8'h00};
    vecs[8]  = '{1, 1'b0, 4'h3, 8'h00, 16'h0300, 8'hA5};
    vecs[9]  = '{2, 1'b1, 4'h6, 8'hC3, 16'h86C3, 8'h00};
    vecs[10] = '{2, 1'b0, 4'hC, 8'h00, 16'h0C00, 8'h5C};

    // reset state
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_cs_n", m_cs_n, 1);
    checkOutput("rst_spi_clk", m_clk, 0);
    checkOutput("rst_mosi", m_mosi, 0);
    checkOutput("rst_rsp_valid", m_rsp_valid, 0);
    checkOutput("rst_rdata", m_rdata, 0);
    checkOutput("rst_ready", m_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready_after_release", m_ready, 1);

    // table-driven transactions
    for (int i = 0; i < 11; i++) begin
      sel = vecs[i].sel;
      d = div_of(sel);
      applyStimulus(vecs[i].write, vecs[i].addr, vecs[i].wdata);
      checkOutput($sformatf("v%0d_mosi_frame", i), mosi_frame, vecs[i].exp_frame);
      checkOutput($sformatf("v%0d_rises", i), rise_cnt, 16);
      checkOutput($sformatf("v%0d_rdata", i), rsp_data, vecs[i].exp_rdata);
      checkOutput($sformatf("v%0d_cs_fall_lat", i), cs_fall_cyc - acc_cyc, 1);
      checkOutput($sformatf("v%0d_rsp_lat", i), rsp_cyc - acc_cyc, 34 * d + 1);
      checkOutput($sformatf("v%0d_ready_lat", i), ready_cyc - acc_cyc, 35 * d + 1);
      checkOutput($sformatf("v%0d_hi_min", i), hi_min, d);
      checkOutput($sformatf("v%0d_hi_max", i), hi_max, d);
      checkOutput($sformatf("v%0d_lo_min", i), lo_min, d);
      checkOutput($sformatf("v%0d_lo_max", i), lo_max, d);
    end

    // back-to-back: valid held high across two requests
    sel = 0;
    a0 = acc_cnt; r0 = rsp_cnt;
    @(posedge clk); #1;
    req_write = 1'b1; req_addr = 4'h5; req_wdata = 8'h11; req_valid = 1'b1;
    t = 0;
    while (acc_cnt == a0 && t < 50) begin @(posedge clk); #1; t++; end
    first_acc = acc_cyc;
    req_write = 1'b0; req_wdata = 8'h00;
    t = 0;
    while (acc_cnt < a0 + 2 && t < 400) begin @(posedge clk); #1; t++; end
    req_valid = 1'b0;
    checkOutput("b2b_accepts", acc_cnt - a0, 2);
    checkOutput("b2b_second_accept_cyc", acc_cyc - first_acc, 141);
    t = 0;
    while (rsp_cnt < r0 + 2 && t < 400) begin @(posedge clk); #1; t++; end
    t = 0;
    while (!m_ready && t < 100) begin @(posedge clk); #1; t++; end
    @(negedge clk); #1;
    checkOutput("b2b_rsps", rsp_cnt - r0, 2);
    checkOutput("b2b_gap_ge_div", (gap_len >= 4), 1);
    checkOutput("b2b_second_frame", mosi_frame, 16'h0500);
    checkOutput("b2b_read_back", rsp_data, 8'h11);

    // reset mid-frame after the 5th rising spi_clk
    r0 = rsp_cnt; f0 = frame_cnt; a0 = acc_cnt;
    @(posedge clk); #1;
    req_write = 1'b1; req_addr = 4'h2; req_wdata = 8'h77; req_valid = 1'b1;
    t = 0;
    while (acc_cnt == a0 && t < 50) begin @(posedge clk); #1; t++; end
    req_valid = 1'b0;
    t = 0;
    while (!(frame_cnt > f0 && rise_cnt >= 5) && t < 400) begin @(posedge clk); #1; t++; end
    checkOutput("midrst_clk_high_before", m_clk, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_cs_n", m_cs_n, 1);
    checkOutput("midrst_spi_clk", m_clk, 0);
    checkOutput("midrst_mosi", m_mosi, 0);
    checkOutput("midrst_rsp_valid", m_rsp_valid, 0);
    checkOutput("midrst_rdata", m_rdata, 0);
    checkOutput("midrst_ready", m_ready, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_ready_after_release", m_ready, 1);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("midrst_no_rsp", rsp_cnt - r0, 0);
    checkOutput("midrst_no_reg_write", regs[2], 8'h00);
    applyStimulus(1'b0, 4'hC, 8'h00);
    checkOutput("midrst_next_frame", mosi_frame, 16'h0C00);
    checkOutput("midrst_next_rdata", rsp_data, 8'h5C);
    checkOutput("midrst_next_rsp_lat", rsp_cyc - acc_cyc, 137);

    // busy: request pulsed during SHIFT must be ignored
    r0 = rsp_cnt; f0 = frame_cnt; a0 = acc_cnt;
    @(posedge clk); #1;
    req_write = 1'b1; req_addr = 4'h9; req_wdata = 8'h42; req_valid = 1'b1;
    t = 0;
    while (acc_cnt == a0 && t < 50) begin @(posedge clk); #1; t++; end
    req_valid = 1'b0;
    t = 0;
    while (!(frame_cnt > f0 && rise_cnt >= 3) && t < 400) begin @(posedge clk); #1; t++; end
    req_write = 1'b0; req_addr = 4'h1; req_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 1'b0;
    t = 0;
    while (rsp_cnt == r0 && t < 400) begin @(posedge clk); #1; t++; end
    repeat (60) @(posedge clk);
    #1;
    checkOutput("busy_accepts", acc_cnt - a0, 1);
    checkOutput("busy_rsps", rsp_cnt - r0, 1);
    checkOutput("busy_frames", frame_cnt - f0, 1);
    checkOutput("busy_frame", mosi_frame, 16'h8942);
    checkOutput("busy_ready_idle", m_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
